// File: rtl/normalizer_f.sv
// normalizer_f: multi-cycle leading-one normalizer for a 23-bit unsigned
// fixed-point value. Produces a 20-bit mantissa with its MSB set (unless the
// exponent floor of -12 is reached first) and a 5-bit two's-complement exponent.
// Optional feature: define NORMF_STICKY_EN to add the `sticky` output, the OR
// of the three work bits dropped below the mantissa.
module normalizer_f (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] ff,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [19:0] y_f,
  output logic [4:0]  exp_ff,
  output logic        zero,
`ifdef NORMF_STICKY_EN
  output logic        sticky,
`endif
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int DATA_W = 23;
  localparam int MANT_W = 20;
  localparam int EXP_W  = 5;
  localparam logic signed [EXP_W-1:0] EXP_MAX = 5'sd3;
  localparam logic signed [EXP_W-1:0] EXP_MIN = -5'sd12;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t state_q, state_n;
  logic   in_ready_q;
  logic   accept;
  logic   finish;

  logic        [DATA_W-1:0] work_p0;
  logic signed [EXP_W-1:0]  exp_p0;

  // Normalization ends once the MSB is set or the exponent hits its floor.
  function automatic logic norm_done(input logic [DATA_W-1:0] w,
                                     input logic signed [EXP_W-1:0] e);
    return w[DATA_W-1] || (e == EXP_MIN);
  endfunction

  // Mantissa is the top MANT_W bits of the work register (truncation).
  function automatic logic [MANT_W-1:0] mant_of(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: MANT_W];
  endfunction

  assign accept   = (state_q == IDLE) && in_ready_q && in_valid;
  assign finish   = (state_q == NORM) && norm_done(work_p0, exp_p0);
  assign in_ready = in_ready_q;

  // Next-state logic for the IDLE -> NORM -> DONE -> IDLE sequence.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept)    state_n = NORM;
      NORM:    if (finish)    state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // State register; in_ready is registered so it stays low through reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      in_ready_q <= (state_n == IDLE);
    end
  end

  // Stage p0: work register and exponent, loaded on accept and shifted per NORM cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      work_p0 <= ff;
      exp_p0  <= EXP_MAX;
    end else if ((state_q == NORM) && !norm_done(work_p0, exp_p0)) begin
      work_p0 <= {work_p0[DATA_W-2:0], 1'b0};
      exp_p0  <= exp_p0 - 5'sd1;
    end
  end

  // Result registers: captured when normalization finishes, held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_f       <= '0;
      exp_ff    <= '0;
      zero      <= 1'b0;
`ifdef NORMF_STICKY_EN
      sticky    <= 1'b0;
`endif
      out_valid <= 1'b0;
    end else if (finish) begin
      y_f       <= mant_of(work_p0);
      exp_ff    <= $unsigned(exp_p0);
      zero      <= (work_p0 == '0);
`ifdef NORMF_STICKY_EN
      sticky    <= |work_p0[2:0];
`endif
      out_valid <= 1'b1;
    end else if ((state_q == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_normalizer_f.sv
// tb_normalizer_f: directed vectors pushed into a scoreboard queue; a monitor
// compares each new result (values and latency) as out_valid rises.
module tb_normalizer_f;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [22:0] ff = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] y_f;
  logic [4:0]  exp_ff;
  logic        zero;
  logic        sticky_w;
  logic        out_valid;
  logic        out_ready = 1'b1;

  normalizer_f dut (
    .clk(clk), .rst(rst), .ff(ff), .in_valid(in_valid), .in_ready(in_ready),
    .y_f(y_f), .exp_ff(exp_ff), .zero(zero),
`ifdef NORMF_STICKY_EN
    .sticky(sticky_w),
`endif
    .out_valid(out_valid), .out_ready(out_ready)
  );

`ifndef NORMF_STICKY_EN
  assign sticky_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] ff;
    logic [19:0] y;
    logic [4:0]  e;
    logic        z;
    logic        s;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare on each rising out_valid.
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_vld) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk($sformatf("y_f[%06h]", x.ff), 32'(y_f), 32'(x.y));
        chk($sformatf("exp_ff[%06h]", x.ff), 32'(exp_ff), 32'(x.e));
        chk($sformatf("zero[%06h]", x.ff), 32'(zero), 32'(x.z));
        chk($sformatf("latency[%06h]", x.ff), 32'(cyc - x.acc), 32'(x.lat));
`ifdef NORMF_STICKY_EN
        chk($sformatf("sticky[%06h]", x.ff), 32'(sticky_w), 32'(x.s));
`endif
      end
    end
    prev_vld <= out_valid;
  end

  task automatic issue(input logic [22:0] v, input logic [19:0] y, input logic [4:0] e,
                       input logic z, input logic s, input int lat);
    int n;
    exp_t x;
    @(negedge clk);
    ff = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      x.ff = v; x.y = y; x.e = e; x.z = z; x.s = s; x.lat = lat; x.acc = cyc + 1;
      q.push_back(x);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  logic [19:0] snap_y;
  logic [4:0]  snap_e;
  logic        snap_z;

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_y_f", 32'(y_f), 32'd0);
    chk("rst_exp_ff", 32'(exp_ff), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors: ff, y_f, exp_ff, zero, sticky, latency
    issue(23'h400000, 20'h80000, 5'b00011, 1'b0, 1'b0, 1);
    issue(23'h001000, 20'h80000, 5'b11001, 1'b0, 1'b0, 11);
    issue(23'h000080, 20'h80000, 5'b10100, 1'b0, 1'b0, 16);
    issue(23'h000000, 20'h00000, 5'b10100, 1'b1, 1'b0, 16);
    issue(23'h400007, 20'h80000, 5'b00011, 1'b0, 1'b1, 1);
    issue(23'h400008, 20'h80001, 5'b00011, 1'b0, 1'b0, 1);
    issue(23'h7FFFFF, 20'hFFFFF, 5'b00011, 1'b0, 1'b1, 1);
    issue(23'h000001, 20'h01000, 5'b10100, 1'b0, 1'b0, 16);
    issue(23'h000100, 20'h80000, 5'b10101, 1'b0, 1'b0, 15);
    issue(23'h123456, 20'h91A2B, 5'b00001, 1'b0, 1'b0, 3);
    drain();

    // Back-pressure: hold out_ready low in DONE
    out_ready = 1'b0;
    issue(23'h002000, 20'h80000, 5'b11010, 1'b0, 1'b0, 10);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_out_valid_seen", 32'(out_valid), 32'd1);
    snap_y = y_f; snap_e = exp_ff; snap_z = zero;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_y_f", 32'(y_f), 32'(snap_y));
      chk("hold_exp_ff", 32'(exp_ff), 32'(snap_e));
      chk("hold_zero", 32'(zero), 32'(snap_z));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Reset mid-normalization discards the operand
    @(negedge clk);
    ff = 23'h000100;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("postrst_no_output", 32'(n), 32'd0);
    issue(23'h000100, 20'h80000, 5'b10101, 1'b0, 1'b0, 15);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/normalizer_f.md
NORMALIZER_F -- requirements
Module: normalizer_f

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port ff, input, 23 bits: unsigned fixed-point value to normalize.
REQ-004 SHALL have port in_valid, input, 1 bit: ff is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts ff.
REQ-006 SHALL have port y_f, output, 20 bits: normalized mantissa.
REQ-007 SHALL have port exp_ff, output, 5 bits: two's-complement exponent, range -12..+3 (5'b10100..5'b00011).
REQ-008 SHALL have port zero, output, 1 bit: the accepted ff was 0.
REQ-009 SHALL have port out_valid, output, 1 bit: y_f, exp_ff and flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.

Function
REQ-011 SHALL satisfy ff == y_f << exp_ff (exp_ff >= 0) or ff == y_f >> -exp_ff (exp_ff < 0) for every non-clamped result, apart from bits dropped by right shifts.
REQ-012 SHALL implement FSM IDLE -> NORM -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-013 SHALL, in IDLE with in_valid=1, load a 23-bit work register with ff, set the exponent register to +3, and enter NORM.
REQ-014 SHALL, in each NORM cycle with work[22]=0 and exponent != -12, shift work left by 1 and decrement the exponent.
REQ-015 SHALL, in NORM with work[22]=1 or exponent == -12, enter DONE and register y_f = work[22:3], exp_ff = exponent, zero = (work == 0), out_valid = 1.
REQ-016 SHALL assert out_valid exactly k+1 cycles after the accept edge, where k = min(22 - leading-one position, 15) (k = 15 for ff = 0); maximum latency is 16 cycles.
REQ-017 SHALL hold y_f, exp_ff, zero and out_valid stable in DONE while out_ready = 0.
REQ-018 SHALL, in DONE with out_ready = 1, deassert out_valid on the next edge and return to IDLE; a new input is accepted no earlier than the following cycle.
REQ-019 SHALL leave y_f[19] = 0 with exp_ff = -12 when the leading one is below bit 7 (denormal result, no error).
REQ-020 SHALL ignore ff and in_valid outside IDLE.

Reset
REQ-021 SHALL, on rst = 1 at any time (including mid-NORM or mid-DONE), immediately force state IDLE, y_f = 0, exp_ff = 5'b00000, zero = 0, out_valid = 0 and in_ready = 0, and discard any in-flight operand.
REQ-022 SHALL drive in_ready = 1 from the first clock edge after rst deasserts.

Configuration
REQ-023 SHALL, with NORMF_STICKY_EN defined, add output sticky (1 bit), registered in REQ-015 as the OR of work[2:0], reset to 0 and held like y_f.
REQ-024 SHALL, without NORMF_STICKY_EN, have no sticky port or logic; all other behaviour is unchanged.

Verification
REQ-025 SHALL test ff = 23'h400000 -> y_f = 20'h80000, exp_ff = 5'b00011, zero = 0, out_valid 1 cycle after accept.
REQ-026 SHALL test ff = 23'h001000 -> y_f = 20'h80000, exp_ff = 5'b11001 (-7), out_valid 11 cycles after accept.
REQ-027 SHALL test ff = 23'h000080 -> y_f = 20'h80000, exp_ff = 5'b10100; and ff = 23'h000000 -> y_f = 0, exp_ff = 5'b10100, zero = 1, both at 16-cycle latency.
REQ-028 SHALL test, with NORMF_STICKY_EN, ff = 23'h400007 -> y_f = 20'h80000, exp_ff = 5'b00011, sticky = 1; and ff = 23'h400008 -> y_f = 20'h80001, sticky = 0.
REQ-029 SHALL test holding out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0; then out_ready = 1 -> out_valid = 0 next cycle, in_ready = 1.
REQ-030 SHALL test rst pulsed 3 cycles after accepting ff = 23'h000100 -> out_valid stays 0, in_ready = 1 after release, and the next operand produces a correct result.
